aes_encrypt_ctrl: RTL and testbench
===================================

Name: aes_encrypt_ctrl

Overview:
- Iterative AES-128 encryption controller.
- Owns one combinational `encryptRound` instance plus a final-round path (subBytes → shiftRows → addRoundKey, no mixColumns). Sequences them over 10 clock cycles, one round per cycle.
- Expands the cipher key on the fly, one round key per cycle.
- Sits between the block-level valid/ready input stream and the ciphertext output stream. Holds one block in flight at a time.

Parameters:
- NR, 10, number of AES rounds. Only 10 (AES-128) is supported; any other value shall fail elaboration.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, plaintext/key pair offered.
- in_ready, output, 1, controller can accept a block.
- in_data, input, 128, plaintext. Bits [127:120] are byte 0 (FIPS-197 order).
- in_key, input, 128, cipher key, same byte order.
- out_valid, output, 1, ciphertext available.
- out_ready, input, 1, downstream accepts ciphertext.
- out_data, output, 128, ciphertext.
- busy, output, 1, high in ROUND or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, state register=0, round key register=0, round counter=0, rcon=8'h01.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: state_reg <= in_data ^ in_key; rk_reg <= in_key; round <= 1; rcon <= 8'h01; go to ROUND.
  - in_data/in_key are sampled only on this edge.
- ROUND:
  - in_ready=0, busy=1.
  - Each cycle, compute next_rk combinationally from rk_reg:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
    - w0 = rk_reg[127:96].
  - Register updates: rk_reg <= next_rk; rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 0).
  - Rounds 1..9: state_reg <= encryptRound(state_reg, next_rk).
  - Round 10: state_reg <= final-round(state_reg, next_rk); go to DONE.
  - round increments each cycle; rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- DONE:
  - out_valid=1, out_data=state_reg, busy=1.
  - out_data is held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: acceptance edge T; out_valid is high after edge T+10, so 10 cycles from accept to first out_valid.
- Throughput: a new block is accepted no earlier than the cycle after the output handshake, i.e. 1 block per ≥12 cycles. No combinational in_ready-from-out_ready path.
- in_valid while not in_ready is ignored; in_data/in_key may change freely.
- out_ready while out_valid=0 is ignored.
- out_data outside DONE is don't-care to consumers but must equal state_reg; no X after reset.
- reset asserted mid-ROUND or in DONE: immediate return to reset values; the in-flight block is discarded and no out_valid pulse follows.
- All arithmetic is GF(2^8) XOR / xtime; the round counter is 4 bits.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32, with out_valid rising exactly 10 cycles after accept.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data stable, in_ready=0. Toggling in_valid with new data is not accepted. Block accepted after out_ready → correct ciphertext.
- Reset at round 5, then re-issue the App. B vector → no spurious out_valid; correct 3925841d… result. Rcon is restarted to 01.
- Back-to-back: in_valid held high with two vectors and out_ready=1 → two correct results. Second accept occurs the cycle after the first output handshake.

Source files
------------

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per cycle, with the round key expanded alongside each round.
// Latency: ciphertext valid 10 cycles after the input handshake; one block in flight at a time.
// Backpressure: in_ready is low from accept until the cycle after the output handshake; output held while out_ready is low.

// AES forward S-box lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // Byte 0 of the table sits in the top bits, so entry b lives at bit offset 8*(255-b) = {~b,3'b000}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table lookup indexed from the high end.
  always_comb begin
    s_o = SBOX[{~a_i, 3'b000} +: 8];
  end
endmodule

// One AES encryption round; final_i drops MixColumns for the last round.
module aes_encrypt_round (
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (.a_i(state_i[127-8*i -: 8]), .s_o(sb[127-8*i -: 8]));
  end

  // ShiftRows: byte (row r, column c) takes the byte from column (c+r) mod 4 of the same row.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns on each 4-byte column.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

  // AddRoundKey on either the full or the final-round datapath.
  always_comb begin
    state_o = (final_i ? sr : mc) ^ rk_i;
  end
endmodule

// Controller: accepts a block, runs NR rounds, presents the ciphertext until taken.
module aes_encrypt_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (NR != 10) begin : g_nr_check
    $error("aes_encrypt_ctrl supports only NR == 10 (AES-128)");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [127:0] next_rk;
  logic [127:0] round_out;
  logic         last_round;

  // Key schedule step: RotWord then SubWord on w3, rcon folded into the top byte.
  always_comb begin
    rot_w3 = {rk_q[23:0], rk_q[31:24]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_key_sub
    aes_sbox u_sbox (.a_i(rot_w3[31-8*i -: 8]), .s_o(sub_w3[31-8*i -: 8]));
  end

  // Next round key, each word chaining from the one before it.
  always_comb begin
    next_rk[127:96] = rk_q[127:96] ^ sub_w3 ^ {rcon_q, 24'h0};
    next_rk[95:64]  = rk_q[95:64]  ^ next_rk[127:96];
    next_rk[63:32]  = rk_q[63:32]  ^ next_rk[95:64];
    next_rk[31:0]   = rk_q[31:0]   ^ next_rk[63:32];
  end

  assign last_round = (round_q == LAST_ROUND);

  aes_encrypt_round u_round (
    .state_i(blk_q),
    .rk_i   (next_rk),
    .final_i(last_round),
    .state_o(round_out)
  );

  // State and datapath registers; reset clears everything except rcon, which restarts at 01.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  // Next-state and output decode; outputs are purely state-derived, so no ready-to-ready path exists.
  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    rk_d      = rk_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = in_data ^ in_key;
          rk_d    = in_key;
          round_d = 4'd1;
          rcon_d  = 8'h01;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        blk_d   = round_out;
        rk_d    = next_rk;
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        round_d = round_q + 4'd1;
        if (last_round) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_data = blk_q;
endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Directed bench for aes_encrypt_ctrl using FIPS-197 vectors.
// Checks reset state, latency, backpressure hold, mid-round reset and back-to-back flow.
// Inputs driven on the falling edge, outputs sampled 1 ns after the rising edge.
module tb_aes_encrypt_ctrl;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encrypt_ctrl #(.NR(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_key   (in_key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Present one block on the falling edge and let the next rising edge take it.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clk);
    in_data  = pt;
    in_key   = key;
    in_valid = 1'b1;
    chk("accept_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid is seen; a budget of 40 bounds the wait.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
  endtask

  // Take the ciphertext with a one-cycle out_ready pulse and confirm the return to idle.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_ready_back"}, {127'd0, in_ready}, 128'd1);
  endtask

  initial begin
    int cyc;
    int spurious;
    logic [127:0] hold;

    // Reset state.
    #12;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(negedge clk);
    reset = 1'b0;

    // FIPS-197 Appendix B with exact latency.
    accept(PT_B, KEY_B);
    chk("b_busy", {127'd0, busy}, 128'd1);
    chk("b_in_ready_low", {127'd0, in_ready}, 128'd0);
    wait_out(cyc);
    chk("b_latency", 128'(cyc), 128'd10);
    chk("b_ct", out_data, CT_B);
    handshake("b");

    // FIPS-197 C.1 with output backpressure and ignored input offers.
    accept(PT_C, KEY_C);
    wait_out(cyc);
    chk("c_latency", 128'(cyc), 128'd10);
    hold = out_data;
    chk("c_ct", hold, CT_C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_data  = {4{$urandom}};
      in_key   = {4{$urandom}};
      @(posedge clk);
      #1;
      chk("bp_hold_data", out_data, CT_C);
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    handshake("c");

    // All-zero key and plaintext, accepted after the backpressured block.
    accept('0, '0);
    wait_out(cyc);
    chk("z_latency", 128'(cyc), 128'd10);
    chk("z_ct", out_data, CT_Z);
    handshake("z");

    // Reset at round 5: block discarded, no output, then a clean re-run.
    accept(PT_B, KEY_B);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_data", out_data, 128'd0);
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious++;
    end
    chk("mid_rst_no_valid", 128'(spurious), 128'd0);
    accept(PT_B, KEY_B);
    wait_out(cyc);
    chk("rerun_latency", 128'(cyc), 128'd10);
    chk("rerun_ct", out_data, CT_B);
    handshake("rerun");

    // Back-to-back: in_valid held high, out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    in_data   = PT_B;
    in_key    = KEY_B;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("btb_first_accept", {127'd0, busy}, 128'd1);
    in_data = PT_C;
    in_key  = KEY_C;
    wait_out(cyc);
    chk("btb1_latency", 128'(cyc), 128'd10);
    chk("btb1_ct", out_data, CT_B);
    @(posedge clk);
    #1;
    chk("btb_gap_valid", {127'd0, out_valid}, 128'd0);
    chk("btb_gap_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    chk("btb_second_accept", {127'd0, busy}, 128'd1);
    in_valid = 1'b0;
    wait_out(cyc);
    chk("btb2_latency", 128'(cyc), 128'd10);
    chk("btb2_ct", out_data, CT_C);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("btb_end_valid", {127'd0, out_valid}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
